instr_register_pipe: RTL



---
 rtl/instr_register_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/instr_register_pipe.sv
// Pipelined instruction register: valid/ready load port, two-stage compute,
// DEPTH-entry result file with a registered read port and occupancy counter.
package instr_register_pipe_pkg;
  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, POW
  } opcode_t;
endpackage

module instr_register_pipe
  import instr_register_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  opcode_t         opcode,
  input  logic [W-1:0]    operand_a,
  input  logic [W-1:0]    operand_b,
  input  logic [AW-1:0]   write_pointer,
  input  logic            read_en,
  input  logic [AW-1:0]   read_pointer,
  output logic            rd_valid,
  output opcode_t         rd_opcode,
  output logic [W-1:0]    rd_a,
  output logic [W-1:0]    rd_b,
  output logic [2*W-1:0]  rd_result,
  output logic            rd_entry_valid,
  output logic            rd_div0,
  input  logic            clear_en,
  output logic [AW:0]     occupancy,
  output logic            busy
);

  localparam int RW = 2 * W;

  typedef struct packed {
    opcode_t       opc;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] result;
  } entry_t;

  logic            accept;
  logic            s1_valid_q;
  opcode_t         s1_opc_q;
  logic [W-1:0]    s1_a_q, s1_b_q;
  logic [AW-1:0]   s1_ptr_q;

  logic [RW-1:0]   a_ext, b_ext, pow_acc, pow_base;
  logic [RW-1:0]   result_d;
  logic            div0_d;

  entry_t          mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, div0_q;
  logic [AW:0]     occupancy_q;

  logic            rd_valid_q, rd_entry_valid_q, rd_div0_q;
  entry_t          rd_entry_q;

  assign load_ready = !reset && !clear_en;
  assign accept     = load_valid && load_ready;
  assign busy       = s1_valid_q;

  // Stage 1: capture the accepted instruction; clear blocks accept, which kills S1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_opc_q   <= ZERO;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ptr_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_opc_q <= opcode;
        s1_a_q   <= operand_a;
        s1_b_q   <= operand_b;
        s1_ptr_q <= write_pointer;
      end
    end
  end

  // Stage 2 compute; POW uses square-and-multiply, truncating every product to RW bits.
  always_comb begin
    // NOTE: combinational temporaries use blocking '=' and get a default before any branch, so no latch is inferred.
    a_ext    = {{W{1'b0}}, s1_a_q};
    b_ext    = {{W{1'b0}}, s1_b_q};
    result_d = '0;
    div0_d   = 1'b0;
    pow_acc  = {{(RW-1){1'b0}}, 1'b1};
    pow_base = a_ext;
    for (int i = 0; i < W; i++) begin
      if (s1_b_q[i]) pow_acc = pow_acc * pow_base;
      pow_base = pow_base * pow_base;
    end
    case (s1_opc_q)
      PASSA:   result_d = a_ext;
      PASSB:   result_d = b_ext;
      ADD:     result_d = a_ext + b_ext;
      SUB:     result_d = a_ext - b_ext;
      MULT:    result_d = a_ext * b_ext;
      DIV, MOD: begin
        if (s1_b_q == '0) div0_d = 1'b1;
        else if (s1_opc_q == DIV) result_d = a_ext / b_ext;
        else result_d = a_ext % b_ext;
      end
      POW:     result_d = pow_acc;
      default: result_d = '0;
    endcase
  end

  // Register file; clear takes priority over a pending stage-2 write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the file is reset because reset must present all-zero entries; this costs a flop reset per bit instead of RAM.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q     <= '0;
      div0_q      <= '0;
      occupancy_q <= '0;
    end else if (clear_en) begin
      valid_q     <= '0;
      div0_q      <= '0;
      occupancy_q <= '0;
    end else if (s1_valid_q) begin
      mem_q[s1_ptr_q]   <= '{opc: s1_opc_q, a: s1_a_q, b: s1_b_q, result: result_d};
      valid_q[s1_ptr_q] <= 1'b1;
      div0_q[s1_ptr_q]  <= div0_d;
      if (!valid_q[s1_ptr_q]) occupancy_q <= occupancy_q + 1'b1;
    end
  end

  // Read port samples pre-write contents, giving read-before-write on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q       <= 1'b0;
      rd_entry_q       <= '0;
      rd_entry_valid_q <= 1'b0;
      rd_div0_q        <= 1'b0;
    end else begin
      rd_valid_q <= read_en;
      if (read_en) begin
        rd_entry_q       <= mem_q[read_pointer];
        rd_entry_valid_q <= valid_q[read_pointer];
        rd_div0_q        <= div0_q[read_pointer];
      end
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_opcode      = rd_entry_q.opc;
  assign rd_a           = rd_entry_q.a;
  assign rd_b           = rd_entry_q.b;
  assign rd_result      = rd_entry_q.result;
  assign rd_entry_valid = rd_entry_valid_q;
  assign rd_div0        = rd_div0_q;
  assign occupancy      = occupancy_q;

endmodule
